// File: rtl/addsub_pkg.sv
// Shared types for the pipelined add/subtract unit.
//   op_t           : operation select (ADD=0, SUB=1); SUB doubles as carry-in
//   addsub_flags_t : result flags {carry, overflow, zero}
package addsub_pkg;

  typedef enum logic {
    ADD = 1'b0,
    SUB = 1'b1
  } op_t;

  typedef struct packed {
    logic carry;
    logic overflow;
    logic zero;
  } addsub_flags_t;

endpackage

// File: rtl/pipelined_addsub_if.sv
// Handshake/data bundle for pipelined_addsub.
//   in_valid/in_ready   : operation handshake (op, in1, in2)
//   out_valid/out_ready : result handshake (s, carry, overflow, zero)
// master = producer of operations / consumer of results; slave = the unit.
interface pipelined_addsub_if #(
  parameter int WIDTH = 32
);
  import addsub_pkg::*;

  logic             in_valid;
  logic             in_ready;
  op_t              op;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             carry;
  logic             overflow;
  logic             zero;

  modport master (
    output in_valid, op, in1, in2, out_ready,
    input  in_ready, out_valid, s, carry, overflow, zero
  );

  modport slave (
    input  in_valid, op, in1, in2, out_ready,
    output in_ready, out_valid, s, carry, overflow, zero
  );

endinterface

// File: rtl/pipelined_addsub_slice.sv
// add_slice: purely combinational SW-bit adder segment.
//   a, b : slice operands (b already inverted for SUB)
//   cin  : carry from the previous segment
//   sum  : slice sum
//   cout : carry out of the slice MSB
module add_slice #(
  parameter int SW = 8
) (
  input  logic [SW-1:0] a,
  input  logic [SW-1:0] b,
  input  logic          cin,
  output logic [SW-1:0] sum,
  output logic          cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{SW{1'b0}}, cin};

endmodule

// File: rtl/pipelined_addsub.sv
// pipelined_addsub: WIDTH-bit add/subtract split into STAGES registered
// carry-chain segments, one op per cycle, global-advance flow control.
//   clk   : core clock
//   rst_n : asynchronous active-low reset
//   bus   : pipelined_addsub_if.slave (operation in, result + flags out)
// Stage i registers the low (i+1)*SW sum bits, the slice carry-out, the
// still-unprocessed upper operand bits and the operand MSBs for overflow.
module pipelined_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  pipelined_addsub_if.slave bus
);

  localparam int SW = WIDTH / STAGES;

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  addsub_flags_t    flags;

  assign b_eff = (bus.op == SUB) ? ~bus.in2 : bus.in2;

  genvar i;
  for (i = 0; i < STAGES; i++) begin : g_stage
    localparam int LO_W  = (i + 1) * SW;
    localparam int REM_W = WIDTH - LO_W;

    logic [SW-1:0]   a_sl;
    logic [SW-1:0]   b_sl;
    logic [SW-1:0]   sum_sl;
    logic            cin;
    logic            cout;
    logic            v_d;
    logic            am_d;
    logic            bm_d;
    logic [LO_W-1:0] lo_d;
    logic [LO_W-1:0] lo_q;
    logic            v_q;
    logic            c_q;
    logic            am_q;
    logic            bm_q;

    if (i == 0) begin : g_src
      assign a_sl = bus.in1[SW-1:0];
      assign b_sl = b_eff[SW-1:0];
      assign cin  = (bus.op == SUB);
      assign v_d  = bus.in_valid;
      assign am_d = bus.in1[WIDTH-1];
      assign bm_d = b_eff[WIDTH-1];
      assign lo_d = sum_sl;
    end else begin : g_src
      assign a_sl = g_stage[i-1].g_rem.a_q[SW-1:0];
      assign b_sl = g_stage[i-1].g_rem.b_q[SW-1:0];
      assign cin  = g_stage[i-1].c_q;
      assign v_d  = g_stage[i-1].v_q;
      assign am_d = g_stage[i-1].am_q;
      assign bm_d = g_stage[i-1].bm_q;
      assign lo_d = {sum_sl, g_stage[i-1].lo_q};
    end

    add_slice #(.SW(SW)) u_slice (
      .a   (a_sl),
      .b   (b_sl),
      .cin (cin),
      .sum (sum_sl),
      .cout(cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q  <= 1'b0;
        c_q  <= 1'b0;
        am_q <= 1'b0;
        bm_q <= 1'b0;
        lo_q <= '0;
      end else if (adv) begin
        v_q  <= v_d;
        c_q  <= cout;
        am_q <= am_d;
        bm_q <= bm_d;
        lo_q <= lo_d;
      end
    end

    // Upper operand bits not yet added; absent in the last stage.
    if (REM_W > 0) begin : g_rem
      logic [REM_W-1:0] a_d;
      logic [REM_W-1:0] b_d;
      logic [REM_W-1:0] a_q;
      logic [REM_W-1:0] b_q;

      if (i == 0) begin : g_rsrc
        assign a_d = bus.in1[WIDTH-1:SW];
        assign b_d = b_eff[WIDTH-1:SW];
      end else begin : g_rsrc
        assign a_d = g_stage[i-1].g_rem.a_q[REM_W+SW-1:SW];
        assign b_d = g_stage[i-1].g_rem.b_q[REM_W+SW-1:SW];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end
  end

  // Whole pipeline moves together; bubbles are kept, never collapsed.
  assign adv          = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = adv;

  assign bus.out_valid  = g_stage[STAGES-1].v_q;
  assign bus.s          = g_stage[STAGES-1].lo_q;

  // Overflow: operands agree in sign but the result sign differs.
  assign flags.carry    = g_stage[STAGES-1].c_q;
  assign flags.overflow = (g_stage[STAGES-1].am_q == g_stage[STAGES-1].bm_q) &&
                          (g_stage[STAGES-1].lo_q[WIDTH-1] != g_stage[STAGES-1].am_q);
  assign flags.zero     = ~|g_stage[STAGES-1].lo_q;

  assign bus.carry    = flags.carry;
  assign bus.overflow = flags.overflow;
  assign bus.zero     = flags.zero;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Testbench for pipelined_addsub: four instances (32/4, 8/1, 64/8, 8/2)
// checked every cycle against an arithmetic reference model, plus literal
// expectations on directed vectors of the 32-bit instance.
module tb_pipelined_addsub;
  import addsub_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipelined_addsub_if #(.WIDTH(32)) if0 ();
  pipelined_addsub_if #(.WIDTH(8))  if1 ();
  pipelined_addsub_if #(.WIDTH(64)) if2 ();
  pipelined_addsub_if #(.WIDTH(8))  if3 ();

  pipelined_addsub #(.WIDTH(32), .STAGES(4)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  pipelined_addsub #(.WIDTH(8),  .STAGES(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  pipelined_addsub #(.WIDTH(64), .STAGES(8)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));
  pipelined_addsub #(.WIDTH(8),  .STAGES(2)) u3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));

  typedef struct {
    logic [63:0] s;
    logic        c;
    logic        o;
    logic        z;
    int          t;
    bit          lat;
    bit          lit;
    logic [63:0] ls;
    logic [2:0]  lf;
  } exp_t;

  exp_t q[4][$];

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  bit          done = 0;
  bit          tmo = 0;
  bit          sweep_done = 0;
  bit          lat_en0 = 1;
  bit          lit_en = 0;
  logic [31:0] lit_s = '0;
  logic [2:0]  lit_f = '0;
  bit          prev_hold = 0;
  logic [63:0] prev_s = '0;
  logic [2:0]  prev_f = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain integer arithmetic on w-bit operands.
  function automatic exp_t model(input int w, input logic sub, input logic [63:0] a, input logic [63:0] b);
    exp_t e;
    logic [64:0] sum;
    logic [63:0] m;
    logic signed [66:0] sa, sb, r, lim;
    m = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    if (sub) begin
      sum = {1'b0, a} - {1'b0, b};
      e.c = (a >= b);
    end else begin
      sum = {1'b0, a} + {1'b0, b};
      e.c = sum[w];
    end
    e.s = sum[63:0] & m;
    sa = $signed({3'b000, a});
    sb = $signed({3'b000, b});
    if (a[w-1]) sa = sa - (67'sd1 <<< w);
    if (b[w-1]) sb = sb - (67'sd1 <<< w);
    r   = sub ? (sa - sb) : (sa + sb);
    lim = 67'sd1 <<< (w - 1);
    e.o = (r >= lim) || (r < -lim);
    e.z = (e.s == 64'd0);
    e.t = 0; e.lat = 0; e.lit = 0; e.ls = '0; e.lf = '0;
    return e;
  endfunction

  task automatic chk(input string nm, input int k, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s inst=%0d got=%h want=%h t=%0t", nm, k, got, want, $time);
    end
  endtask

  task automatic obs(input int k, input int st, input int w, input logic iv, input logic ir,
                     input logic sub, input logic [63:0] a, input logic [63:0] b,
                     input logic ov, input logic ordy, input logic [63:0] s,
                     input logic c, input logic o, input logic z, input bit le);
    exp_t e;
    chk("in_ready", k, 64'(ir), 64'(!ov || ordy));
    if (k == 0) begin
      if (prev_hold) begin
        chk("hold_s", k, s, prev_s);
        chk("hold_flags", k, {61'b0, c, o, z}, {61'b0, prev_f});
      end
      prev_hold = ov && !ordy;
      prev_s    = s;
      prev_f    = {c, o, z};
    end
    if (ov && ordy) begin
      if (q[k].size() == 0) begin
        chk("spurious_out", k, 64'(ov), 64'd0);
      end else begin
        e = q[k].pop_front();
        chk("s", k, s, e.s);
        chk("flags", k, {61'b0, c, o, z}, {61'b0, e.c, e.o, e.z});
        if (e.lat) chk("latency", k, 64'(cyc - e.t), 64'(st));
        if (e.lit) begin
          chk("lit_s", k, s, e.ls);
          chk("lit_flags", k, {61'b0, c, o, z}, {61'b0, e.lf});
          chk("model_pin", k, {e.s[60:0], e.c, e.o, e.z}, {e.ls[60:0], e.lf});
        end
      end
    end
    if (iv && ir) begin
      e     = model(w, sub, a, b);
      e.t   = cyc;
      e.lat = le;
      e.lit = (k == 0) && lit_en;
      e.ls  = {32'b0, lit_s};
      e.lf  = lit_f;
      q[k].push_back(e);
    end
  endtask

  // Single compare process: every cycle, and immediately on async reset.
  always begin
    @(negedge clk or negedge rst_n);
    #1;
    if (done || cyc > 20000) begin
      chk("watchdog", 0, 64'(cyc > 20000), 64'd0);
      chk("timeout", 0, 64'(tmo), 64'd0);
      for (int k = 0; k < 4; k++) chk("drain", k, 64'(q[k].size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end else if (!rst_n) begin
      chk("rst_out_valid", 0, 64'(if0.out_valid), 64'd0);
      chk("rst_s", 0, {32'b0, if0.s}, 64'd0);
      chk("rst_flags", 0, {61'b0, if0.carry, if0.overflow, if0.zero}, 64'd1);
      chk("rst_in_ready", 0, 64'(if0.in_ready), 64'd1);
      chk("rst_out_valid_w64", 2, 64'(if2.out_valid), 64'd0);
      for (int k = 0; k < 4; k++) q[k].delete();
      prev_hold = 0;
    end else begin
      obs(0, 4, 32, if0.in_valid, if0.in_ready, if0.op == SUB, {32'b0, if0.in1}, {32'b0, if0.in2},
          if0.out_valid, if0.out_ready, {32'b0, if0.s}, if0.carry, if0.overflow, if0.zero, lat_en0);
      obs(1, 1, 8, if1.in_valid, if1.in_ready, if1.op == SUB, {56'b0, if1.in1}, {56'b0, if1.in2},
          if1.out_valid, if1.out_ready, {56'b0, if1.s}, if1.carry, if1.overflow, if1.zero, 1'b1);
      obs(2, 8, 64, if2.in_valid, if2.in_ready, if2.op == SUB, if2.in1, if2.in2,
          if2.out_valid, if2.out_ready, if2.s, if2.carry, if2.overflow, if2.zero, 1'b1);
      obs(3, 2, 8, if3.in_valid, if3.in_ready, if3.op == SUB, {56'b0, if3.in1}, {56'b0, if3.in2},
          if3.out_valid, if3.out_ready, {56'b0, if3.s}, if3.carry, if3.overflow, if3.zero, 1'b1);
    end
  end

  task automatic send(input bit sub, input logic [31:0] a, input logic [31:0] b,
                      input bit le, input logic [31:0] ls, input logic [2:0] lf);
    int n;
    if0.in_valid = 1'b1;
    if0.op       = sub ? SUB : ADD;
    if0.in1      = a;
    if0.in2      = b;
    lit_en       = le;
    lit_s        = ls;
    lit_f        = lf;
    @(negedge clk);
    n = 0;
    while (!if0.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) tmo = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic send_rand();
    logic [63:0] r;
    r = {$urandom, $urandom};
    send(r[0], r[63:32], r[31:0], 1'b0, 32'd0, 3'd0);
  endtask

  task automatic idle(input int n);
    if0.in_valid = 1'b0;
    lit_en       = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Main instance: directed, back-to-back, backpressure, random flow, reset.
  initial begin
    logic [63:0] r;
    int n;
    if0.in_valid = 1'b0; if0.op = ADD; if0.in1 = '0; if0.in2 = '0; if0.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    //   op  A             B             s             {c,o,z}
    send(0, 32'hFFFF_FFFF, 32'h0000_0001, 1, 32'h0000_0000, 3'b101);
    send(1, 32'h8000_0000, 32'h0000_0001, 1, 32'h7FFF_FFFF, 3'b110);
    send(1, 32'h0000_0005, 32'h0000_0007, 1, 32'hFFFF_FFFE, 3'b000);
    send(0, 32'h7FFF_FFFF, 32'h0000_0001, 1, 32'h8000_0000, 3'b010);
    send(1, 32'h0000_0003, 32'h0000_0003, 1, 32'h0000_0000, 3'b101);
    for (int j = 0; j < 8; j++) send_rand();
    idle(8);

    // Fill with the consumer stalled, hold 5 cycles, then drain.
    lat_en0 = 0;
    if0.out_ready = 1'b0;
    for (int j = 0; j < 4; j++) send_rand();
    r = {$urandom, $urandom};
    if0.in_valid = 1'b1; if0.op = SUB; if0.in1 = r[31:0]; if0.in2 = r[63:32]; lit_en = 0;
    repeat (5) begin @(posedge clk); #1; end
    if0.out_ready = 1'b1;
    send(1, r[31:0], r[63:32], 1'b0, 32'd0, 3'd0);
    idle(8);

    // Random valid/ready traffic with simultaneous in/out transfers.
    for (int j = 0; j < 60; j++) begin
      r = {$urandom, $urandom};
      if0.in_valid  = r[0];
      if0.op        = r[1] ? SUB : ADD;
      if0.in1       = {r[63:36], r[7:4]};
      if0.in2       = r[35:4];
      if0.out_ready = (r[3:2] != 2'b00);
      @(posedge clk); #1;
    end
    if0.out_ready = 1'b1;
    idle(8);
    lat_en0 = 1;

    n = 0;
    while (!sweep_done && n < 2000) begin @(posedge clk); n++; end
    if (!sweep_done) tmo = 1;
    #1;

    // Reset mid-flight: three ops in the pipe, partial-cycle reset pulse.
    for (int j = 0; j < 3; j++) send_rand();
    if0.in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    idle(10);

    send(0, 32'h1234_5678, 32'h1111_1111, 1, 32'h2345_6789, 3'b000);
    idle(8);
    done = 1;
  end

  // Parameter sweep instances: random ops with periodic bubbles, out_ready=1.
  initial begin
    logic [63:0] r1, r2, r3;
    if1.in_valid = 1'b0; if1.op = ADD; if1.in1 = '0; if1.in2 = '0; if1.out_ready = 1'b1;
    if2.in_valid = 1'b0; if2.op = ADD; if2.in1 = '0; if2.in2 = '0; if2.out_ready = 1'b1;
    if3.in_valid = 1'b0; if3.op = ADD; if3.in1 = '0; if3.in2 = '0; if3.out_ready = 1'b1;
    wait (rst_n === 1'b1);
    @(posedge clk); #1;
    for (int n = 0; n < 40; n++) begin
      r1 = {$urandom, $urandom};
      r2 = {$urandom, $urandom};
      r3 = {$urandom, $urandom};
      if1.in_valid = (n % 5) != 3;
      if1.op = r1[63] ? SUB : ADD; if1.in1 = r1[7:0]; if1.in2 = r1[15:8];
      if2.in_valid = (n % 7) != 5;
      if2.op = r2[0] ? SUB : ADD; if2.in1 = r2; if2.in2 = r3 ^ r1;
      if3.in_valid = (n % 4) != 2;
      if3.op = r3[63] ? SUB : ADD; if3.in1 = r3[7:0]; if3.in2 = r3[15:8];
      @(posedge clk); #1;
    end
    if1.in_valid = 1'b0;
    if2.in_valid = 1'b0;
    if3.in_valid = 1'b0;
    repeat (12) @(posedge clk);
    sweep_done = 1;
  end

endmodule
